// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a byte-lane BRAM with a registered read port.
// Optional macro MISALIGN_TRAP_EN: reject misaligned halfword/word accesses with resp_err 01.
module load_store_unit #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int          MEM_ADDR_W = 11
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [2:0]            i_req_funct3,
    input  logic [31:0]           i_req_addr,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [31:0]           o_resp_rdata,
    output logic [1:0]            o_resp_err,
    output logic                  o_bram_write,
    output logic [2:0]            o_bram_funct3,
    output logic [MEM_ADDR_W-1:0] o_bram_addr,
    output logic [31:0]           o_bram_din,
    input  logic [31:0]           i_bram_dout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_READ    = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [2:0]            r_funct3;
    logic [MEM_ADDR_W-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic [1:0]            r_err;

    logic                  w_hs;
    logic                  w_illegal;
    logic                  w_range;
    logic                  w_misalign;
    logic [1:0]            w_err;
    logic [MEM_ADDR_W-1:0] w_bram_off;
    logic [31:0]           w_ext;

    assign w_hs = i_req_valid && (r_state == S_IDLE);

    always_comb begin
        if (i_req_write)
            w_illegal = i_req_funct3[2] || (i_req_funct3 == 3'b011);
        else
            w_illegal = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11);
    end

    assign w_range = (i_req_addr[31:MEM_ADDR_W] != ADDR_BASE[31:MEM_ADDR_W]);

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                        ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Highest-priority error wins: illegal, then range, then alignment.
    always_comb begin
        w_err = 2'b00;
        if (w_illegal)       w_err = 2'b11;
        else if (w_range)    w_err = 2'b10;
        else if (w_misalign) w_err = 2'b01;
    end

    assign w_bram_off = i_req_addr[MEM_ADDR_W-1:0] - ADDR_BASE[MEM_ADDR_W-1:0];

    always_comb begin
        w_ext = '0;
        case (r_funct3)
            3'b000:  w_ext = {{24{i_bram_dout[7]}}, i_bram_dout[7:0]};
            3'b001:  w_ext = {{16{i_bram_dout[15]}}, i_bram_dout[15:0]};
            3'b010:  w_ext = i_bram_dout;
            3'b100:  w_ext = {24'd0, i_bram_dout[7:0]};
            3'b101:  w_ext = {16'd0, i_bram_dout[15:0]};
            default: w_ext = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    if (w_err != 2'b00)   w_state_nxt = S_RESP;
                    else if (i_req_write) w_state_nxt = S_WRITE;
                    else                  w_state_nxt = S_READ;
                end
            end
            S_WRITE:   w_state_nxt = S_RESP;
            S_READ:    w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_RESP;
            S_RESP:    if (i_resp_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // rdata is cleared at accept so stores and errors answer with zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= '0;
        end else begin
            if (w_hs) begin
                r_funct3 <= i_req_funct3;
                r_addr   <= w_bram_off;
                r_wdata  <= i_req_wdata;
                r_rdata  <= '0;
                r_err    <= w_err;
            end
            if (r_state == S_CAPTURE)
                r_rdata <= w_ext;
        end
    end

    assign o_req_ready   = (r_state == S_IDLE);
    assign o_resp_valid  = (r_state == S_RESP);
    assign o_bram_write  = (r_state == S_WRITE);
    assign o_resp_rdata  = r_rdata;
    assign o_resp_err    = r_err;
    assign o_bram_funct3 = r_funct3;
    assign o_bram_addr   = r_addr;
    assign o_bram_din    = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-lane BRAM model (registered read, wraps mod 2 KiB).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        bram_write;
    logic [2:0]  bram_funct3;
    logic [10:0] bram_addr;
    logic [31:0] bram_din, bram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
        .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
        .o_bram_write(bram_write), .o_bram_funct3(bram_funct3), .o_bram_addr(bram_addr),
        .o_bram_din(bram_din), .i_bram_dout(bram_dout)
    );

    // BRAM model
    logic [7:0]  mem [0:2047];
    logic [10:0] a1, a2, a3;
    assign a1 = bram_addr + 11'd1;
    assign a2 = bram_addr + 11'd2;
    assign a3 = bram_addr + 11'd3;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        bram_dout = 32'h0;
    end

    always @(posedge clk) begin
        if (bram_write) begin
            mem[bram_addr] <= bram_din[7:0];
            if (bram_funct3[1:0] != 2'b00) mem[a1] <= bram_din[15:8];
            if (bram_funct3[1:0] == 2'b10) begin
                mem[a2] <= bram_din[23:16];
                mem[a3] <= bram_din[31:24];
            end
        end
        bram_dout <= {mem[a3], mem[a2], mem[a1], mem[bram_addr]};
    end

    // Latency counts edges with the accepting edge as 1. lat 98/99 = timeout.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int hold,
                          output logic [31:0] rd, output logic [1:0] er, output int lat,
                          output int bw_cnt, output logic [10:0] wa, output logic [31:0] wd,
                          output logic stable);
        int waited;
        rd = '0; er = '0; lat = 0; bw_cnt = 0; wa = '0; wd = '0; stable = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            lat = 98;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bram_write) begin
                bw_cnt++;
                wa = bram_addr;
                wd = bram_din;
            end
            if (resp_valid) break;
            @(posedge clk);
            lat++;
        end
        if (!resp_valid) begin
            lat = 99;
            return;
        end
        rd = resp_rdata;
        er = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!resp_valid || req_ready || resp_rdata !== rd || resp_err !== er || bram_write)
                stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    logic [31:0] rd, wd;
    logic [1:0]  er;
    logic [10:0] wa;
    logic        st;
    int          lat, bw;

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        n_checks++; if (resp_err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", resp_err); end
        n_checks++; if (bram_write !== 1'b0) begin n_fail++; $display("FAIL reset_bram_write: got %b want 0", bram_write); end
        n_checks++; if (bram_addr !== 11'h0) begin n_fail++; $display("FAIL reset_bram_addr: got %h want 0", bram_addr); end
        n_checks++; if (bram_din !== 32'h0) begin n_fail++; $display("FAIL reset_bram_din: got %h want 0", bram_din); end
        n_checks++; if (bram_funct3 !== 3'h0) begin n_fail++; $display("FAIL reset_bram_funct3: got %h want 0", bram_funct3); end
        rst = 1'b0;
    endtask

    task automatic test_word();
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", lat); end
        n_checks++; if (bw !== 1) begin n_fail++; $display("FAIL sw_write_cycles: got %0d want 1", bw); end
        n_checks++; if (wa !== 11'h010) begin n_fail++; $display("FAIL sw_addr: got %h want 010", wa); end
        n_checks++; if (wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_din: got %h want deadbeef", wd); end
        n_checks++; if (rd !== 32'h0 || er !== 2'b00) begin n_fail++; $display("FAIL sw_resp: got %h/%b want 0/00", rd, er); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", lat); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", rd); end
        n_checks++; if (er !== 2'b00 || bw !== 0) begin n_fail++; $display("FAIL lw_err_bw: got %b/%0d want 00/0", er, bw); end
    endtask

    task automatic test_byte_ext();
        do_req(1'b1, 3'b000, 32'h21, 32'h00000080, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (bw !== 1 || wa !== 11'h021) begin n_fail++; $display("FAIL sb_write: got %0d@%h want 1@021", bw, wa); end
        do_req(1'b0, 3'b000, 32'h21, 32'h0, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_sext: got %h want ffffff80", rd); end
        do_req(1'b0, 3'b100, 32'h21, 32'h0, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_zext: got %h want 00000080", rd); end
        do_req(1'b0, 3'b001, 32'h20, 32'h0, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (rd !== 32'hFFFF8000) begin n_fail++; $display("FAIL lh_sext: got %h want ffff8000", rd); end
        do_req(1'b0, 3'b101, 32'h20, 32'h0, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (rd !== 32'h00008000) begin n_fail++; $display("FAIL lhu_zext: got %h want 00008000", rd); end
    endtask

    task automatic test_misaligned();
        // byte 0x13 = 0x11, byte 0x14 = 0xA5
        do_req(1'b1, 3'b010, 32'h10, 32'h11223344, 0, rd, er, lat, bw, wa, wd, st);
        do_req(1'b1, 3'b000, 32'h14, 32'h000000A5, 0, rd, er, lat, bw, wa, wd, st);
        do_req(1'b0, 3'b001, 32'h13, 32'h0, 0, rd, er, lat, bw, wa, wd, st);
`ifdef MISALIGN_TRAP_EN
        n_checks++; if (er !== 2'b01 || rd !== 32'h0) begin n_fail++; $display("FAIL lh_mis_err: got %b/%h want 01/0", er, rd); end
        n_checks++; if (lat !== 1 || bw !== 0) begin n_fail++; $display("FAIL lh_mis_noaccess: got lat %0d bw %0d want 1/0", lat, bw); end
        do_req(1'b1, 3'b010, 32'h22, 32'h55555555, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (er !== 2'b01 || bw !== 0) begin n_fail++; $display("FAIL sw_mis: got %b/%0d want 01/0", er, bw); end
`else
        n_checks++; if (er !== 2'b00 || rd !== 32'hFFFFA511) begin n_fail++; $display("FAIL lh_mis_pass: got %b/%h want 00/ffffa511", er, rd); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL lh_mis_latency: got %0d want 3", lat); end
`endif
    endtask

    task automatic test_errors();
        do_req(1'b0, 3'b010, 32'h800, 32'h0, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (er !== 2'b10 || rd !== 32'h0) begin n_fail++; $display("FAIL range_800: got %b/%h want 10/0", er, rd); end
        n_checks++; if (lat !== 1 || bw !== 0) begin n_fail++; $display("FAIL range_latency: got lat %0d bw %0d want 1/0", lat, bw); end
        do_req(1'b1, 3'b010, 32'h8000_0010, 32'h1, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (er !== 2'b10 || bw !== 0) begin n_fail++; $display("FAIL range_store_hi: got %b/%0d want 10/0", er, bw); end
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (er !== 2'b11 || rd !== 32'h0) begin n_fail++; $display("FAIL illegal_ld011: got %b/%h want 11/0", er, rd); end
        do_req(1'b0, 3'b110, 32'h10, 32'h0, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (er !== 2'b11) begin n_fail++; $display("FAIL illegal_ld110: got %b want 11", er); end
        do_req(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (er !== 2'b11 || bw !== 0) begin n_fail++; $display("FAIL illegal_st100: got %b/%0d want 11/0", er, bw); end
        do_req(1'b0, 3'b011, 32'h801, 32'h0, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (er !== 2'b11) begin n_fail++; $display("FAIL prio_illegal: got %b want 11", er); end
        do_req(1'b0, 3'b010, 32'h802, 32'h0, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (er !== 2'b10) begin n_fail++; $display("FAIL prio_range: got %b want 10", er); end
        do_req(1'b0, 3'b010, 32'h7FC, 32'h0, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (er !== 2'b00 || lat !== 3) begin n_fail++; $display("FAIL edge_7fc: got %b lat %0d want 00/3", er, lat); end
    endtask

    task automatic test_hold();
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL hold_stable: got %b want 1", st); end
        n_checks++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL hold_data: got %h want 11223344", rd); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_idle: got %b want 1", req_ready); end
    endtask

    task automatic test_back_to_back();
        do_req(1'b1, 3'b001, 32'h30, 32'h0000BEEF, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
        do_req(1'b0, 3'b101, 32'h30, 32'h0, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (rd !== 32'h0000BEEF || lat !== 3) begin n_fail++; $display("FAIL b2b_lhu: got %h lat %0d want 0000beef/3", rd, lat); end
    endtask

    task automatic test_reset_write();
        do_req(1'b1, 3'b010, 32'h40, 32'h12345678, 0, rd, er, lat, bw, wa, wd, st);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_checks++; if (bram_write !== 1'b1) begin n_fail++; $display("FAIL rstw_in_write: got %b want 1", bram_write); end
        rst = 1'b1;
        #1;
        n_checks++; if (bram_write !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rstw_async: got bw %b rdy %b want 0/1", bram_write, req_ready); end
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 3'b010, 32'h40, 32'h0, 0, rd, er, lat, bw, wa, wd, st);
        n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL rstw_old_value: got %h want 12345678", rd); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_word();
        test_byte_ext();
        test_misaligned();
        test_errors();
        test_hold();
        test_back_to_back();
        test_reset_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
